adj_ctrl: RTL and testbench



---
 rtl/clock_pkg.sv | 21 ++
 rtl/btn_debounce.sv | 59 +++++
 rtl/adj_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_adj_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared select codes and adjust-controller types for the clock counters.
package clock_pkg;

  localparam int unsigned SEL_W = 3;

  localparam logic [SEL_W-1:0] SEL_RUN   = 3'd0;
  localparam logic [SEL_W-1:0] SEL_MIN   = 3'd1;
  localparam logic [SEL_W-1:0] SEL_HOUR  = 3'd2;
  localparam logic [SEL_W-1:0] SEL_DAY   = 3'd3;
  localparam logic [SEL_W-1:0] SEL_MONTH = 3'd4;
  localparam logic [SEL_W-1:0] SEL_YEAR  = 3'd5;
  localparam logic [SEL_W-1:0] SEL_SEC   = 3'd6;

  // Step-request FSM: waiting, request latched, request on the bus.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_STEP  = 2'd2
  } adj_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Raw button -> 2-flop sync -> stable-count debounce, level plus rise pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 20
) (
  input  logic clk_1kHz,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             r_s1;
  logic             r_s2;
  logic             r_level;
  logic             r_rise;
  logic [CNT_W-1:0] r_cnt;
  logic             w_diff;
  logic             w_done;

  assign w_diff = (r_s2 != r_level);
  assign w_done = w_diff && (r_cnt == CNT_LAST);

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge clk_1kHz or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_btn;
      r_s2 <= r_s1;
    end
  end

  // Level flips only after the synced input has disagreed for DEBOUNCE_CYC cycles.
  always_ff @(posedge clk_1kHz or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_rise <= w_done & r_s2;
      if (!w_diff || w_done) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_done) begin
        r_level <= r_s2;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;

endmodule

// File: rtl/adj_ctrl.sv
// Front-panel adjust controller: item select, windowed up/down steps, timeout.
module adj_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 20,
  parameter int unsigned NUM_ITEMS    = 6,
  parameter int unsigned TIMEOUT_S    = 30
) (
  input  logic             clk_1kHz,
  input  logic             rst_n,
  input  logic             clk_1Hz,
  input  logic             btn_mode,
  input  logic             btn_up,
  input  logic             btn_down,
  output logic [SEL_W-1:0] select_item,
  output logic             up,
  output logic             down,
  output logic             adjusting
);

  localparam int unsigned NUM_BTN  = 3;
  localparam int unsigned BTN_MODE = 0;
  localparam int unsigned BTN_UP   = 1;
  localparam int unsigned BTN_DOWN = 2;
  localparam int unsigned TO_W     = (TIMEOUT_S > 1) ? $clog2(TIMEOUT_S) : 1;
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_S - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_ITEMS);

  // Next select code with wrap back to run mode.
  function automatic logic [SEL_W-1:0] sel_inc(input logic [SEL_W-1:0] s);
    return (s >= SEL_LAST) ? SEL_RUN : s + SEL_W'(1);
  endfunction

  logic [NUM_BTN-1:0] w_btn_raw;
  logic               w_lvl  [NUM_BTN];
  logic               w_rise [NUM_BTN];

  adj_state_e       r_state, w_state_nxt;
  logic             r_dir, w_dir_nxt;
  logic [SEL_W-1:0] r_sel, w_sel_nxt;
  logic             r_pend, w_pend_nxt;
  logic [SEL_W-1:0] r_pend_sel, w_pend_sel_nxt;
  logic             r_up, w_up_nxt;
  logic             r_down, w_down_nxt;
  logic             r_adj;
  logic [TO_W-1:0]  r_to, w_to_nxt;
  logic             r_hz_s1, r_hz_s2, r_hz_d;

  logic             w_f_tick;
  logic             w_mode_p, w_up_p, w_down_p, w_any_press;
  logic             w_timeout;
  logic [SEL_W-1:0] w_pend_base, w_pend_val;
  logic             w_pend_any;

  assign w_btn_raw = {btn_down, btn_up, btn_mode};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_db
    btn_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_db (
      .clk_1kHz(clk_1kHz),
      .rst_n   (rst_n),
      .i_btn   (w_btn_raw[g]),
      .o_level (w_lvl[g]),
      .o_rise  (w_rise[g])
    );
  end

  assign w_mode_p    = w_rise[BTN_MODE];
  assign w_up_p      = w_rise[BTN_UP];
  assign w_down_p    = w_rise[BTN_DOWN];
  assign w_any_press = w_mode_p | w_up_p | w_down_p;

  // Synchronize clk_1Hz as data and keep one extra stage for falling-edge detect.
  always_ff @(posedge clk_1kHz or negedge rst_n) begin
    if (!rst_n) begin
      r_hz_s1 <= 1'b0;
      r_hz_s2 <= 1'b0;
      r_hz_d  <= 1'b0;
    end else begin
      r_hz_s1 <= clk_1Hz;
      r_hz_s2 <= r_hz_s1;
      r_hz_d  <= r_hz_s2;
    end
  end

  assign w_f_tick = r_hz_d & ~r_hz_s2;

  // Mode presses during a step window accumulate here until the window ends.
  assign w_pend_base = r_pend ? r_pend_sel : r_sel;
  assign w_pend_val  = w_mode_p ? sel_inc(w_pend_base) : w_pend_base;
  assign w_pend_any  = r_pend | w_mode_p;

  assign w_timeout = w_f_tick && (r_sel != SEL_RUN) && !w_any_press && (r_to == TO_LAST);

  // Next-state and next-output logic; timeout has the last word.
  always_comb begin
    w_state_nxt    = r_state;
    w_dir_nxt      = r_dir;
    w_sel_nxt      = r_sel;
    w_pend_nxt     = r_pend;
    w_pend_sel_nxt = r_pend_sel;
    w_up_nxt       = r_up;
    w_down_nxt     = r_down;
    w_to_nxt       = r_to;

    if (w_any_press || (r_sel == SEL_RUN)) begin
      w_to_nxt = '0;
    end else if (w_f_tick) begin
      w_to_nxt = r_to + TO_W'(1);
    end

    unique case (r_state)
      ST_IDLE: begin
        if ((r_sel != SEL_RUN) && (w_up_p || w_down_p)) begin
          w_state_nxt = ST_ARMED;
          w_dir_nxt   = w_up_p;
        end
      end
      ST_ARMED: begin
        if (w_up_p) begin
          w_dir_nxt = 1'b1;
        end else if (w_down_p) begin
          w_dir_nxt = 1'b0;
        end
        if (w_f_tick) begin
          w_state_nxt = ST_STEP;
          w_up_nxt    = w_dir_nxt;
          w_down_nxt  = ~w_dir_nxt;
        end
      end
      ST_STEP: begin
        if (w_f_tick) begin
          if (w_pend_any) begin
            w_sel_nxt   = w_pend_val;
            w_pend_nxt  = 1'b0;
            w_up_nxt    = 1'b0;
            w_down_nxt  = 1'b0;
            w_state_nxt = ST_IDLE;
          end else if (!(r_dir ? w_lvl[BTN_UP] : w_lvl[BTN_DOWN])) begin
            w_up_nxt    = 1'b0;
            w_down_nxt  = 1'b0;
            w_state_nxt = ST_IDLE;
          end
        end else if (w_mode_p) begin
          w_pend_nxt     = 1'b1;
          w_pend_sel_nxt = w_pend_val;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_up_nxt    = 1'b0;
        w_down_nxt  = 1'b0;
      end
    endcase

    if (w_mode_p && (r_state != ST_STEP)) begin
      w_sel_nxt   = sel_inc(r_sel);
      w_state_nxt = ST_IDLE;
      w_up_nxt    = 1'b0;
      w_down_nxt  = 1'b0;
    end

    if (w_timeout) begin
      w_sel_nxt   = SEL_RUN;
      w_state_nxt = ST_IDLE;
      w_up_nxt    = 1'b0;
      w_down_nxt  = 1'b0;
      w_pend_nxt  = 1'b0;
      w_to_nxt    = '0;
    end
  end

  // State and output registers; adjusting tracks the next select code.
  always_ff @(posedge clk_1kHz or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_dir      <= 1'b0;
      r_sel      <= SEL_RUN;
      r_pend     <= 1'b0;
      r_pend_sel <= SEL_RUN;
      r_up       <= 1'b0;
      r_down     <= 1'b0;
      r_adj      <= 1'b0;
      r_to       <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_dir      <= w_dir_nxt;
      r_sel      <= w_sel_nxt;
      r_pend     <= w_pend_nxt;
      r_pend_sel <= w_pend_sel_nxt;
      r_up       <= w_up_nxt;
      r_down     <= w_down_nxt;
      r_adj      <= (w_sel_nxt != SEL_RUN);
      r_to       <= w_to_nxt;
    end
  end

  assign select_item = r_sel;
  assign up          = r_up;
  assign down        = r_down;
  assign adjusting   = r_adj;

endmodule

// File: tb/tb_adj_ctrl.sv
// Directed scoreboard bench for adj_ctrl with a 100-cycle clk_1Hz.
module tb_adj_ctrl;
  import clock_pkg::*;

  logic             clk;
  logic             rst_n;
  logic             clk_1Hz;
  logic             btn_mode;
  logic             btn_up;
  logic             btn_down;
  logic [SEL_W-1:0] select_item;
  logic             up;
  logic             down;
  logic             adjusting;

  typedef struct {
    string       tag;
    int unsigned val;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic step_seen;

  adj_ctrl #(
    .DEBOUNCE_CYC(4),
    .NUM_ITEMS   (6),
    .TIMEOUT_S   (30)
  ) dut (
    .clk_1kHz   (clk),
    .rst_n      (rst_n),
    .clk_1Hz    (clk_1Hz),
    .btn_mode   (btn_mode),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .select_item(select_item),
    .up         (up),
    .down       (down),
    .adjusting  (adjusting)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // 1 Hz stand-in: 100 fast cycles per period, edges offset from clk edges.
  initial begin
    clk_1Hz = 1'b0;
    #2;
    forever #500 clk_1Hz = ~clk_1Hz;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input string tag, input int unsigned v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic pop_check(input int unsigned obs);
    exp_t e;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $error("FAIL sb_underflow: observed %0d expected none", obs);
      return;
    end
    e = sb_q.pop_front();
    assert (obs === e.val) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
    end
  endtask

  // Press mode for 10 cycles; returns cycles until select_item changed.
  task automatic press_mode(output int lat);
    logic [SEL_W-1:0] prev;
    prev = select_item;
    lat  = -1;
    btn_mode = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (lat < 0 && select_item != prev) lat = k;
      if (k == 10) btn_mode = 1'b0;
    end
    cyc(15);
  endtask

  task automatic tap(input bit use_up, input bit use_down);
    btn_up   = use_up;
    btn_down = use_down;
    cyc(10);
    btn_up   = 1'b0;
    btn_down = 1'b0;
  endtask

  // Follow the window that starts after the next clk_1Hz fall.
  task automatic measure_window(input bit want_down, output int off, output int len,
                                output int rises, output int other);
    logic o;
    logic prev_hz;
    off = -1; len = 0; rises = 0; other = 0;
    @(negedge clk_1Hz);
    for (int j = 1; j <= 150 && off < 0; j++) begin
      @(negedge clk);
      o = want_down ? down : up;
      if (want_down ? up : down) other++;
      if (o) off = j;
    end
    if (off < 0) return;
    len = 1;
    prev_hz = clk_1Hz;
    for (int j = 0; j < 1000; j++) begin
      @(negedge clk);
      o = want_down ? down : up;
      if (want_down ? up : down) other++;
      if (!o) break;
      len++;
      if (clk_1Hz && !prev_hz) rises++;
      prev_hz = clk_1Hz;
    end
  endtask

  // Advance until n clk_1Hz falls have been seen, noting any step output.
  task automatic wait_falls(input int n);
    int   cnt;
    logic prev;
    cnt  = 0;
    prev = clk_1Hz;
    while (cnt < n) begin
      @(negedge clk);
      if (up || down) step_seen = 1'b1;
      if (prev && !clk_1Hz) cnt++;
      prev = clk_1Hz;
    end
  endtask

  initial begin
    int   lat, off, len, rises, other;
    int   first, lowi, gap;
    logic prev_up, prev_hz, bad;

    rst_n = 1'b0; btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    step_seen = 1'b0;

    // Reset state
    cyc(3);
    push_exp("rst_sel", 0);  pop_check(32'(select_item));
    push_exp("rst_up", 0);   pop_check(32'(up));
    push_exp("rst_down", 0); pop_check(32'(down));
    push_exp("rst_adj", 0);  pop_check(32'(adjusting));
    rst_n = 1'b1;

    // Quiet run mode, then up held while in run mode
    bad = 1'b0;
    push_exp("idle500", 0);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (select_item != SEL_RUN || up || down || adjusting) bad = 1'b1;
    end
    pop_check(32'(bad));
    bad = 1'b0;
    push_exp("run_up_ignored", 0);
    btn_up = 1'b1;
    for (int i = 0; i < 30; i++) begin @(negedge clk); if (up || down) bad = 1'b1; end
    btn_up = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (up || down || adjusting) bad = 1'b1;
    end
    pop_check(32'(bad));

    // Mode sequence 1..6 then wrap to 0
    for (int i = 1; i <= 7; i++) begin
      push_exp("mode_seq", 32'(i % 7));
      push_exp("mode_adj", (i % 7 != 0) ? 1 : 0);
      press_mode(lat);
      pop_check(32'(select_item));
      pop_check(32'(adjusting));
      if (i == 1) begin
        push_exp("mode_latency_5_8", 1);
        pop_check((lat >= 5 && lat <= 8) ? 1 : 0);
      end
    end
    push_exp("mode_to_min", 32'(SEL_MIN));
    press_mode(lat);
    pop_check(32'(select_item));

    // Single tap: one full window, one clk_1Hz rising edge inside
    @(negedge clk_1Hz);
    cyc(10);
    push_exp("tap_offset", 3);
    push_exp("tap_len", 100);
    push_exp("tap_hz_rises", 1);
    push_exp("tap_no_down", 0);
    tap(1'b1, 1'b0);
    measure_window(1'b0, off, len, rises, other);
    pop_check(32'(off)); pop_check(32'(len)); pop_check(32'(rises)); pop_check(32'(other));

    // Hold 350 cycles: back-to-back windows, drop at first fall after release
    @(negedge clk_1Hz);
    cyc(10);
    first = -1; lowi = -1; gap = 0; len = 0; rises = 0;
    prev_up = 1'b0; prev_hz = clk_1Hz;
    btn_up = 1'b1;
    for (int i = 1; i <= 700; i++) begin
      @(negedge clk);
      if (i == 350) btn_up = 1'b0;
      if (up) begin
        if (first < 0) first = i;
        else if (!prev_up) gap = 1;
        len++;
        if (clk_1Hz && !prev_hz) rises++;
      end else if (prev_up && lowi < 0) begin
        lowi = i;
      end
      prev_up = up;
      prev_hz = clk_1Hz;
    end
    push_exp("hold_first", 93);      pop_check(32'(first));
    push_exp("hold_len_3_or_4", 1);  pop_check((len == 300 || len == 400) ? 1 : 0);
    push_exp("hold_rises_per_win", 1); pop_check((rises * 100 == len) ? 1 : 0);
    push_exp("hold_gap", 0);         pop_check(32'(gap));
    push_exp("hold_drop_after_rel", 1); pop_check((lowi > 350 && lowi <= 453) ? 1 : 0);

    // Up and down in the same cycle: up wins
    @(negedge clk_1Hz);
    cyc(10);
    push_exp("both_offset", 3);
    push_exp("both_len", 100);
    push_exp("both_no_down", 0);
    tap(1'b1, 1'b1);
    measure_window(1'b0, off, len, rises, other);
    pop_check(32'(off)); pop_check(32'(len)); pop_check(32'(other));

    // Down while ARMED for up: direction switches to down
    @(negedge clk_1Hz);
    cyc(10);
    push_exp("armed_down_offset", 3);
    push_exp("armed_down_len", 100);
    push_exp("armed_down_no_up", 0);
    tap(1'b1, 1'b0);
    cyc(20);
    tap(1'b0, 1'b1);
    measure_window(1'b1, off, len, rises, other);
    pop_check(32'(off)); pop_check(32'(len)); pop_check(32'(other));

    // Mode press inside a step window is deferred to the window end
    @(negedge clk_1Hz);
    cyc(10);
    tap(1'b1, 1'b0);
    @(negedge clk_1Hz);
    cyc(3);
    push_exp("s7_up_on", 1); pop_check(32'(up));
    cyc(20);
    btn_mode = 1'b1;
    cyc(10);
    btn_mode = 1'b0;
    cyc(30);
    push_exp("s7_sel_mid", 32'(SEL_MIN)); pop_check(32'(select_item));
    @(negedge clk_1Hz);
    cyc(2);
    push_exp("s7_up_last", 1);            pop_check(32'(up));
    push_exp("s7_sel_last", 32'(SEL_MIN)); pop_check(32'(select_item));
    cyc(1);
    push_exp("s7_up_end", 0);              pop_check(32'(up));
    push_exp("s7_sel_end", 32'(SEL_HOUR)); pop_check(32'(select_item));
    push_exp("s7_adj_end", 1);             pop_check(32'(adjusting));

    // Timeout: 30th f_tick after the last press returns to run mode
    step_seen = 1'b0;
    wait_falls(28);
    cyc(4);
    push_exp("to_sel_29", 32'(SEL_HOUR)); pop_check(32'(select_item));
    push_exp("to_no_repeat", 0);          pop_check(32'(step_seen));
    wait_falls(1);
    cyc(1);
    push_exp("to_sel_before", 32'(SEL_HOUR)); pop_check(32'(select_item));
    cyc(1);
    push_exp("to_sel_fire", 32'(SEL_RUN)); pop_check(32'(select_item));
    push_exp("to_adj_fire", 0);            pop_check(32'(adjusting));

    // Reset mid-window drops up at once with no step completion
    press_mode(lat);
    push_exp("rst2_sel_pre", 32'(SEL_MIN)); pop_check(32'(select_item));
    @(negedge clk_1Hz);
    cyc(10);
    tap(1'b1, 1'b0);
    @(negedge clk_1Hz);
    cyc(3);
    push_exp("rst2_up_on", 1); pop_check(32'(up));
    cyc(20);
    rst_n = 1'b0;
    #1;
    push_exp("rst2_up_now", 0);  pop_check(32'(up));
    push_exp("rst2_sel_now", 0); pop_check(32'(select_item));
    push_exp("rst2_adj_now", 0); pop_check(32'(adjusting));
    cyc(3);
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (up || down || select_item != SEL_RUN) bad = 1'b1;
    end
    push_exp("rst2_quiet", 0); pop_check(32'(bad));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
